// File: rtl/min_int_serial_if.sv
// min_int_serial_if: operand/result handshake bundle for min_int_serial
interface min_int_serial_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Y;
    logic             a_lt;
    modport master (output in_valid, A, B, out_ready, input in_ready, out_valid, Y, a_lt);
    modport slave  (input in_valid, A, B, out_ready, output in_ready, out_valid, Y, a_lt);
endinterface

// File: rtl/min_int_serial.sv
// min_int_serial: bit-serial MSB-first signed minimum of A and B.
// Define MIN_INT_SERIAL_EARLY_EXIT_EN to finish on the first differing bit.
module min_int_serial #(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             rst,
    min_int_serial_if.slave bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] a_q, b_q, y;
    logic [IW-1:0]    idx;
    logic             decided, sel, a_lt;
    logic             diff, a_small, dec_n, sel_n, fin;
    assign diff    = a_q[idx] ^ b_q[idx];
    // the sign bit weighs negatively, so a set A sign bit means A is smaller
    assign a_small = (idx == IW'(WIDTH - 1)) ? a_q[idx] : b_q[idx];
    assign dec_n   = decided | diff;
    assign sel_n   = decided ? sel : (diff & a_small);
`ifdef MIN_INT_SERIAL_EARLY_EXIT_EN
    assign fin     = (idx == '0) | (~decided & diff);
`else
    assign fin     = (idx == '0);
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx     <= '0;
            decided <= 1'b0;
            sel     <= 1'b0;
            y       <= '0;
            a_lt    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_q     <= bus.A;
                    b_q     <= bus.B;
                    idx     <= IW'(WIDTH - 1);
                    decided <= 1'b0;
                    sel     <= 1'b0;
                    state   <= CMP;
                end
                CMP: begin
                    decided <= dec_n;
                    sel     <= sel_n;
                    idx     <= idx - IW'(1);
                    if (fin) begin
                        y     <= sel_n ? a_q : b_q;
                        a_lt  <= sel_n;
                        state <= DONE;
                    end
                end
                DONE: if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.Y         = y;
    assign bus.a_lt      = a_lt;
endmodule

// File: tb/tb_min_int_serial.sv
// tb_min_int_serial: directed checks of min_int_serial against a behavioural min model
module tb_min_int_serial;
    localparam int W = 32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_y = '0;
    logic         exp_lt = 1'b0;
    min_int_serial_if #(.WIDTH(W)) bus ();
    min_int_serial #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (!rst) begin
            chk("excl", 64'(bus.in_ready & bus.out_valid), 64'd0);
            if (bus.out_valid) begin
                chk("mon_y", 64'(bus.Y), 64'(exp_y));
                chk("mon_lt", 64'(bus.a_lt), 64'(exp_lt));
            end
        end
    end
    function automatic int lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MIN_INT_SERIAL_EARLY_EXIT_EN
        for (int k = 0; k < W; k++) if (a[W-1-k] != b[W-1-k]) return k + 1;
`endif
        return W;
    endfunction
    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] ly,
                       input logic llt, input int hold);
        int n;
        @(negedge clk);
        exp_lt = $signed(a) < $signed(b);
        exp_y  = exp_lt ? a : b;
        chk("lit_y", 64'(exp_y), 64'(ly));
        chk("lit_lt", 64'(exp_lt), 64'(llt));
        chk("idle_ready", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.A = a;
        bus.B = b;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (!bus.out_valid && n < 100);
        chk("latency", 64'(n), 64'(lat(a, b)));
        chk("y", 64'(bus.Y), 64'(ly));
        chk("a_lt", 64'(bus.a_lt), 64'(llt));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.in_valid = ~bus.in_valid;
            bus.A = $urandom;
            bus.B = $urandom;
            chk("hold_ready", 64'(bus.in_ready), 64'd0);
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_y", 64'(bus.Y), 64'(ly));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("handoff_valid", 64'(bus.out_valid), 64'd0);
        chk("handoff_ready", 64'(bus.in_ready), 64'd1);
        chk("idle_y", 64'(bus.Y), 64'(ly));
        chk("idle_lt", 64'(bus.a_lt), 64'(llt));
        bus.out_ready = 1'b0;
    endtask
    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.A = '0;
        bus.B = '0;
        #12;
        chk("rst_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_y", 64'(bus.Y), 64'd0);
        chk("rst_lt", 64'(bus.a_lt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run(32'd5, 32'hFFFFFFFD, 32'hFFFFFFFD, 1'b0, 0);
        run(32'h80000000, 32'h7FFFFFFF, 32'h80000000, 1'b1, 0);
        run(32'h12345678, 32'h12345678, 32'h12345678, 1'b0, 0);
        run(32'h10, 32'h11, 32'h10, 1'b1, 5);
        run(32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0, 0);
        run(32'h0, 32'h1, 32'h0, 1'b1, 1);
        run(32'h00010000, 32'h0, 32'h0, 1'b0, 0);
        run(32'hFFFFFF9C, 32'd7, 32'hFFFFFF9C, 1'b1, 2);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.A = 32'h00000001;
        bus.B = 32'h00000002;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(posedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_y", 64'(bus.Y), 64'd0);
        chk("mid_rst_lt", 64'(bus.a_lt), 64'd0);
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("abandoned", 64'(bus.out_valid), 64'd0);
        run(32'h00000003, 32'h80000001, 32'h80000001, 1'b0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/min_int_serial.md
MIN_INT_SERIAL -- requirements
Module: min_int_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits (signed two's complement).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, operand pair offered.
REQ-005 The block SHALL have port in_ready, output, 1, block can accept an operand pair.
REQ-006 The block SHALL have ports A and B, input, WIDTH each, signed operands sampled on the accepting edge.
REQ-007 The block SHALL have port out_valid, output, 1, result available.
REQ-008 The block SHALL have port out_ready, input, 1, consumer takes the result.
REQ-009 The block SHALL have port Y, output, WIDTH, registered signed minimum of the accepted A and B.
REQ-010 The block SHALL have port a_lt, output, 1, registered flag, 1 iff accepted A < accepted B (signed).

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, CMP, DONE.
REQ-012 The block SHALL assert in_ready only in IDLE; out_valid only in DONE.
REQ-013 In IDLE, the block SHALL, on in_valid && in_ready, latch A and B, set bit index to WIDTH-1, clear the decided flag and the select flag, and enter CMP.
REQ-014 In CMP, the block SHALL examine one bit index per edge, MSB first, decrementing the index.
REQ-015 At index WIDTH-1 (sign), the block SHALL treat a=1,b=0 as A smaller and a=0,b=1 as B smaller.
REQ-016 At any lower index, the block SHALL treat a=0,b=1 as A smaller and a=1,b=0 as B smaller.
REQ-017 Only the first differing bit SHALL set decided and the select flag; later bits SHALL NOT change them.
REQ-018 The block SHALL leave CMP for DONE on the edge that processes index 0, giving exactly WIDTH edges in CMP (macro off).
REQ-019 On entering DONE, the block SHALL load Y with the latched A if select=1, else the latched B (ties give B), and load a_lt with select.
REQ-020 In DONE, the block SHALL hold Y and a_lt stable until out_ready is high; on that edge it SHALL return to IDLE.
REQ-021 Y and a_lt SHALL keep their last value in IDLE until the next DONE entry.
REQ-022 The block SHALL ignore in_valid in CMP and DONE; operands are not re-sampled.
REQ-023 out_valid and in_ready SHALL never be high in the same cycle; a new pair is accepted no earlier than one edge after the DONE handoff.

Reset
REQ-024 While rst is high, the block SHALL set state IDLE, and Y, a_lt, out_valid, the index, and the decided and select flags to 0; in_ready SHALL be 1.
REQ-025 Reset asserted in CMP or DONE SHALL abandon the operation with no result delivered.

Configuration
REQ-026 The block SHALL support macro MIN_INT_SERIAL_EARLY_EXIT_EN.
REQ-027 With MIN_INT_SERIAL_EARLY_EXIT_EN defined, the block SHALL go CMP->DONE on the edge that sets decided, so latency is k+1 edges, k = 0-based MSB-first position of the first differing bit; equal operands still take WIDTH edges.
REQ-028 Without MIN_INT_SERIAL_EARLY_EXIT_EN, latency SHALL always be WIDTH edges per REQ-018.
REQ-029 Y and a_lt SHALL be identical in both configurations.

Verification
REQ-030 A=5, B=0xFFFFFFFD -> Y=0xFFFFFFFD, a_lt=0; out_valid after 32 edges (macro off) or 1 edge (macro on).
REQ-031 A=0x80000000, B=0x7FFFFFFF -> Y=0x80000000, a_lt=1; 32 edges (off) or 1 edge (on).
REQ-032 A=B=0x12345678 -> Y=0x12345678, a_lt=0; 32 edges in both configurations.
REQ-033 A=0x10, B=0x11 -> Y=0x10, a_lt=1; 32 edges in both configurations.
REQ-034 out_ready low for 5 cycles in DONE with in_valid pulsing -> Y and a_lt stable, in_ready=0, no new pair latched; IDLE on the first edge with out_ready=1.
REQ-035 rst pulsed on the 10th CMP edge -> Y=0, a_lt=0, out_valid=0, in_ready=1 immediately; next accepted pair completes normally.
